// File: rtl/random_arbiter.sv
// -----------------------------------------------------------------------------
// random_arbiter
//   Shares one 16-bit LFSR source (random_gen) between NUM_REQ gameplay
//   requesters. Round-robin arbitration picks one requester at a time. Each
//   grant draws LFSR words through a power-of-two mask and rejects draws above
//   the requester's inclusive limit. After MAX_RETRY rejected draws, the last
//   draw is folded back into range.
//
//   Optional feature macro: RAND_ARB_STATS_EN
//     When defined, the block adds output stat_rejects, a saturating count of
//     rejected draws.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active-high
//   req          per-requester request level, held until ack
//   limit        inclusive upper bound; requester i uses [16*i+15:16*i]
//   rnd_get      step strobe to random_gen (high while in STEP)
//   rnd_in       current random_gen output
//   ack          one-cycle onehot pulse; rnd_out is valid for that requester
//   rnd_out      bounded random value; holds between acks
//   grant_id     index of the requester being served
//   busy         high whenever the arbiter is not idle
//   stat_rejects (RAND_ARB_STATS_EN only) saturating rejected-draw count
// -----------------------------------------------------------------------------
module random_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_RETRY = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [16*NUM_REQ-1:0] limit,
  output logic                  rnd_get,
  input  logic [15:0]           rnd_in,
  output logic [NUM_REQ-1:0]    ack,
  output logic [15:0]           rnd_out,
  output logic [2:0]            grant_id,
  output logic                  busy
`ifdef RAND_ARB_STATS_EN
  ,
  output logic [15:0]           stat_rejects
`endif
);

  localparam int RW = $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [2:0]         gid_q, gid_d;
  logic [15:0]        lim_q, lim_d;
  logic [15:0]        mask_q, mask_d;
  logic [15:0]        out_q, out_d;
  logic [RW-1:0]      retry_q, retry_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               busy_q;

  logic               win_found;
  logic [2:0]         win_idx;
  logic [15:0]        win_lim;
  logic               gnt_req;
  logic [NUM_REQ-1:0] gid_onehot;
  logic [15:0]        v;
  logic [RW-1:0]      retry_inc;

  // Smallest all-ones mask covering x: smear the highest set bit downward.
  function automatic logic [15:0] smear(input logic [15:0] x);
    logic [15:0] m;
    m = x;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    return m;
  endfunction

  // Round-robin search: first set request strictly after the last winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!win_found && req[i] && (i == (int'(ptr_q) + k) % NUM_REQ)) begin
          win_found = 1'b1;
          win_idx   = 3'(i);
        end
      end
    end
  end

  always_comb begin
    win_lim    = '0;
    gnt_req    = 1'b0;
    gid_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == 3'(i)) win_lim = limit[16*i +: 16];
      if (gid_q == 3'(i)) begin
        gnt_req       = req[i];
        gid_onehot[i] = 1'b1;
      end
    end
  end

  assign v         = rnd_in & mask_q;
  assign retry_inc = retry_q + RW'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    lim_d   = lim_q;
    mask_d  = mask_q;
    retry_d = retry_q;
    out_d   = out_q;
    ack_d   = '0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          gid_d   = win_idx;
          ptr_d   = win_idx;
          lim_d   = win_lim;
          mask_d  = smear(win_lim);
          retry_d = '0;
          state_d = STEP;
        end
      end
      STEP: begin
        // The LFSR step at this edge happens whether or not the grant survives.
        state_d = gnt_req ? CHECK : IDLE;
      end
      CHECK: begin
        if (!gnt_req) begin
          state_d = IDLE;
        end else if (v <= lim_q) begin
          out_d   = v;
          ack_d   = gid_onehot;
          state_d = IDLE;
        end else if (retry_inc != RW'(MAX_RETRY)) begin
          retry_d = retry_inc;
          state_d = STEP;
        end else begin
          // v > lim_q here, so lim_q < 0xFFFF and the subtraction lands in range.
          out_d   = v - (lim_q + 16'd1);
          ack_d   = gid_onehot;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 3'(NUM_REQ - 1);
      gid_q   <= '0;
      lim_q   <= '0;
      mask_q  <= '0;
      retry_q <= '0;
      out_q   <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      lim_q   <= lim_d;
      mask_q  <= mask_d;
      retry_q <= retry_d;
      out_q   <= out_d;
      ack_q   <= ack_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign rnd_get  = (state_q == STEP);
  assign ack      = ack_q;
  assign rnd_out  = out_q;
  assign grant_id = gid_q;
  assign busy     = busy_q;

`ifdef RAND_ARB_STATS_EN
  logic [15:0] rej_q;
  logic        rej_inc;

  // Counts every rejected draw, including the final draw that gets folded.
  assign rej_inc = (state_q == CHECK) && gnt_req && (v > lim_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rej_q <= '0;
    end else if (rej_inc && (rej_q != 16'hFFFF)) begin
      rej_q <= rej_q + 16'd1;
    end
  end

  assign stat_rejects = rej_q;
`endif

endmodule
